// File: rtl/bus_ram_responder_if.sv
// System-bus bundle between an initiator (master) and a memory responder (slave).
// Request side carries single/burst reads and writes with byte enables;
// response side returns read data, one valid cycle per beat, never stalled.
interface bus_ram_responder_if #(
    parameter int AW = 23,
    parameter int DW = 16
);
    logic              req_read;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic              req_burst;
    logic [2:0]        req_burst_len;
    logic [DW-1:0]     req_wdata;
    logic [DW/8-1:0]   req_byteenable;
    logic              req_ready;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_rdata;

    modport master (
        output req_read, req_write, req_addr, req_burst, req_burst_len,
               req_wdata, req_byteenable,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_read, req_write, req_addr, req_burst, req_burst_len,
               req_wdata, req_byteenable,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bus_ram_responder.sv
// Block-RAM-backed stand-in for the SDRAM controller on the system bus.
// Fixed read latency (RAM read + RD_LATENCY-1 output registers), single and
// burst transfers, byte-masked writes. Addresses alias modulo 2**MEM_AW words.
module bus_ram_responder #(
    parameter int AW         = 23,
    parameter int DW         = 16,
    parameter int MEM_AW     = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_ram_responder_if.slave   bus
);
    localparam int DEPTH = 1 << MEM_AW;
    localparam int NB    = DW / 8;

    typedef enum logic [1:0] {
        IDLE,
        WBURST,
        RBURST
    } state_t;

    state_t              state_reg, state_next;
    logic [MEM_AW-1:0]   ptr_reg, ptr_next;
    logic [2:0]          rem_reg, rem_next;

    logic                wr_en;
    logic [MEM_AW-1:0]   wr_addr;
    logic                rd_issue;
    logic [MEM_AW-1:0]   rd_addr;

    logic [MEM_AW-1:0]   addr_lo;
    logic                burst_start;
    logic [DW-1:0]       ram_q;
    logic [DW-1:0]       out_stage;
    logic [RD_LATENCY-1:0] vld_reg;
    logic [DW-1:0]       hold_reg;

    // Upper address bits are deliberately ignored (aliasing); fold them here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr;

    assign addr_lo     = bus.req_addr[MEM_AW-1:0];
    assign burst_start = bus.req_burst && (bus.req_burst_len != 3'd0);

    // State, burst pointer and remaining-beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            rem_reg   <= rem_next;
        end
    end

    // Next-state logic plus RAM write/read strobes for the current cycle.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        rem_next   = rem_reg;
        wr_en      = 1'b0;
        wr_addr    = ptr_reg;
        rd_issue   = 1'b0;
        rd_addr    = ptr_reg;
        case (state_reg)
            IDLE: begin
                // A simultaneous read is dropped: the write takes priority.
                if (bus.req_write) begin
                    wr_en   = 1'b1;
                    wr_addr = addr_lo;
                    if (burst_start) begin
                        ptr_next   = addr_lo + MEM_AW'(1);
                        rem_next   = bus.req_burst_len;
                        state_next = WBURST;
                    end
                end else if (bus.req_read) begin
                    rd_issue = 1'b1;
                    rd_addr  = addr_lo;
                    if (burst_start) begin
                        ptr_next   = addr_lo + MEM_AW'(1);
                        rem_next   = bus.req_burst_len;
                        state_next = RBURST;
                    end
                end
            end
            WBURST: begin
                // Beats arrive at the initiator's pace; idle cycles just wait.
                if (bus.req_write) begin
                    wr_en    = 1'b1;
                    ptr_next = ptr_reg + MEM_AW'(1);
                    rem_next = rem_reg - 3'd1;
                    if (rem_reg == 3'd1) begin
                        state_next = IDLE;
                    end
                end
            end
            RBURST: begin
                // Read beats go out back to back with the request side held off.
                rd_issue = 1'b1;
                ptr_next = ptr_reg + MEM_AW'(1);
                rem_next = rem_reg - 3'd1;
                if (rem_reg == 3'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_reg != RBURST);

    // One 8-bit RAM per byte lane so each lane has its own write enable.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q_reg;

            // Byte-lane write port; writes are suppressed while reset is held.
            always_ff @(posedge clk) begin
                if (wr_en && !rst && bus.req_byteenable[gi]) begin
                    lane_mem[wr_addr] <= bus.req_wdata[8*gi +: 8];
                end
            end

            // Registered read port (first cycle of read latency).
            always_ff @(posedge clk) begin
                if (rd_issue) begin
                    lane_q_reg <= lane_mem[rd_addr];
                end
            end

            assign ram_q[8*gi +: 8] = lane_q_reg;
        end
    endgenerate

    // Remaining RD_LATENCY-1 data stages after the RAM output register.
    generate
        if (RD_LATENCY == 1) begin : g_no_pipe
            assign out_stage = ram_q;
        end else begin : g_pipe
            logic [DW-1:0] pipe_reg [RD_LATENCY-1];

            // Plain shift of read data alongside the valid pipe.
            always_ff @(posedge clk) begin
                pipe_reg[0] <= ram_q;
                for (int i = 1; i < RD_LATENCY - 1; i++) begin
                    pipe_reg[i] <= pipe_reg[i-1];
                end
            end

            assign out_stage = pipe_reg[RD_LATENCY-2];
        end
    endgenerate

    // Valid pipe; reset discards every in-flight response immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg <= '0;
        end else begin
            vld_reg[0] <= rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_reg[i] <= vld_reg[i-1];
            end
        end
    end

    // Last delivered word, so rdata stays stable between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg <= '0;
        end else if (vld_reg[RD_LATENCY-1]) begin
            hold_reg <= out_stage;
        end
    end

    assign bus.rsp_valid = vld_reg[RD_LATENCY-1];
    assign bus.rsp_rdata = vld_reg[RD_LATENCY-1] ? out_stage : hold_reg;

endmodule
